// File: rtl/align_addsub_if.sv
// Operand/result channel of the FPU add/sub align stage.
// Operand fields: [36] sign, [35:28] exponent, [27] hidden, [26:4] fraction, [3:1] grs, [0] pad.
interface align_addsub_if;
    logic        in_valid;
    logic        in_ready;
    logic [36:0] N_A;
    logic [36:0] N_B;
    logic        op;
    logic        out_valid;
    logic        out_ready;
    logic        res_sign;
    logic [7:0]  res_exp;
    logic [28:0] res_sum;
    logic        res_zero;

    modport master (
        output in_valid, N_A, N_B, op, out_ready,
        input  in_ready, out_valid, res_sign, res_exp, res_sum, res_zero
    );

    modport slave (
        input  in_valid, N_A, N_B, op, out_ready,
        output in_ready, out_valid, res_sign, res_exp, res_sum, res_zero
    );
endinterface

// File: rtl/align_addsub.sv
// Three-stage exponent compare/swap, sticky-preserving align and significand add/sub.
// Produces an unnormalized sum for the normalize/round stage.
module align_addsub (
    input  logic           clk,
    input  logic           rst,
    align_addsub_if.slave  bus
);
    // Handshake: a pair transfers on a rising edge with in_valid & in_ready; a result
    // transfers on a rising edge with out_valid & out_ready. A held result stalls the
    // whole pipeline, so in_ready is simply the inverse of that stall.
    logic stall;
    assign stall        = bus.out_valid & ~bus.out_ready;
    assign bus.in_ready = ~stall;

    // Stage 1 combinational: compare and swap
    logic        sign_a, sign_b;
    logic [7:0]  exp_a, exp_b;
    logic [27:0] sig_a, sig_b;
    logic        a_big;

    always_comb begin
        sign_a = bus.N_A[36];
        sign_b = bus.N_B[36] ^ bus.op;
        exp_a  = bus.N_A[35:28];
        exp_b  = bus.N_B[35:28];
        sig_a  = bus.N_A[27:0];
        sig_b  = bus.N_B[27:0];
        a_big  = (exp_a > exp_b) || ((exp_a == exp_b) && (sig_a >= sig_b));
    end

    logic        s1_valid, s1_sign, s1_eff_sub, s1_zero_sign;
    logic [7:0]  s1_exp, s1_d;
    logic [27:0] s1_big, s1_small;

    // Stage 2 combinational: right shift, everything at or below bit 1 folds into sticky
    logic [27:0] shr, low_mask, shifted;
    logic        sticky;

    always_comb begin
        shr = s1_small >> s1_d;
        if (s1_d >= 8'd26) begin
            low_mask = '1;
        end else begin
            low_mask = (28'd4 << s1_d[4:0]) - 28'd1;
        end
        sticky = |(s1_small & low_mask);
        if (s1_d == 8'd0) begin
            shifted = {s1_small[27:1], 1'b0};
        end else begin
            shifted = {shr[27:2], sticky, 1'b0};
        end
    end

    logic        s2_valid, s2_sign, s2_eff_sub, s2_zero_sign;
    logic [7:0]  s2_exp;
    logic [27:0] s2_big, s2_shifted;

    // Stage 3 combinational: the swap guarantees big >= shifted, so subtraction never wraps
    logic [28:0] sum;
    always_comb begin
        if (s2_eff_sub) begin
            sum = {1'b0, s2_big} - {1'b0, s2_shifted};
        end else begin
            sum = {1'b0, s2_big} + {1'b0, s2_shifted};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_sign       <= 1'b0;
            s1_eff_sub    <= 1'b0;
            s1_zero_sign  <= 1'b0;
            s1_exp        <= '0;
            s1_d          <= '0;
            s1_big        <= '0;
            s1_small      <= '0;
            s2_valid      <= 1'b0;
            s2_sign       <= 1'b0;
            s2_eff_sub    <= 1'b0;
            s2_zero_sign  <= 1'b0;
            s2_exp        <= '0;
            s2_big        <= '0;
            s2_shifted    <= '0;
            bus.out_valid <= 1'b0;
            bus.res_sign  <= 1'b0;
            bus.res_exp   <= '0;
            bus.res_sum   <= '0;
            bus.res_zero  <= 1'b0;
        end else if (!stall) begin
            s1_valid     <= bus.in_valid;
            s1_sign      <= a_big ? sign_a : sign_b;
            s1_exp       <= a_big ? exp_a : exp_b;
            s1_big       <= a_big ? sig_a : sig_b;
            s1_small     <= a_big ? sig_b : sig_a;
            s1_d         <= a_big ? (exp_a - exp_b) : (exp_b - exp_a);
            s1_eff_sub   <= sign_a ^ sign_b;
            s1_zero_sign <= sign_a & sign_b;

            s2_valid     <= s1_valid;
            s2_sign      <= s1_sign;
            s2_exp       <= s1_exp;
            s2_big       <= s1_big;
            s2_shifted   <= shifted;
            s2_eff_sub   <= s1_eff_sub;
            s2_zero_sign <= s1_zero_sign;

            // An exact zero is +0 unless both effective operands were negative
            bus.out_valid <= s2_valid;
            bus.res_exp   <= s2_exp;
            bus.res_sum   <= sum;
            bus.res_zero  <= (sum == 29'd0);
            bus.res_sign  <= (sum == 29'd0) ? s2_zero_sign : s2_sign;
        end
    end
endmodule

// File: tb/tb_align_addsub.sv
// Randomized scoreboard bench for align_addsub with directed corner vectors,
// backpressure, mid-stream reset and latency measurement.
module tb_align_addsub;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    align_addsub_if bus ();
    align_addsub dut (.clk(clk), .rst(rst), .bus(bus));

    int          n_checks = 0;
    int          n_fail   = 0;
    longint      cyc      = 0;
    logic [38:0] exp_q[$];
    logic        held     = 1'b0;
    logic [38:0] held_val;
    logic [38:0] cur;
    logic        done     = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exhausted, required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [38:0] act, input logic [38:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [36:0] mk(input logic s, input logic [7:0] e, input logic [27:0] m);
        return {s, e, m};
    endfunction

    // Reference: pick the larger magnitude, align bit by bit, then signed-magnitude arithmetic
    function automatic logic [38:0] ref_model(input logic [36:0] a, input logic [36:0] b, input logic o);
        logic        sa, sb, big_s, zero;
        logic [7:0]  big_e;
        logic [27:0] big_m, small_m, sh;
        int          d;
        logic        st;
        longint      s;
        logic [28:0] s29;
        sa = a[36];
        sb = b[36] ^ o;
        if (a[35:0] >= b[35:0]) begin
            big_s = sa; big_e = a[35:28]; big_m = a[27:0]; small_m = b[27:0];
            d = int'(a[35:28]) - int'(b[35:28]);
        end else begin
            big_s = sb; big_e = b[35:28]; big_m = b[27:0]; small_m = a[27:0];
            d = int'(b[35:28]) - int'(a[35:28]);
        end
        sh = '0;
        if (d == 0) begin
            sh = small_m;
            sh[0] = 1'b0;
        end else begin
            st = 1'b0;
            for (int i = 0; i < 28; i++) begin
                if (small_m[i]) begin
                    if (i - d >= 2) sh[i - d] = 1'b1;
                    else st = 1'b1;
                end
            end
            sh[1] = st;
        end
        if (sa != sb) s = longint'(big_m) - longint'(sh);
        else s = longint'(big_m) + longint'(sh);
        s29  = 29'(s);
        zero = (s == 0);
        return {zero ? (sa & sb) : big_s, big_e, s29, zero};
    endfunction

    task automatic rand_pair(output logic [36:0] a, output logic [36:0] b, output logic o);
        logic [7:0]  ea, eb;
        logic [27:0] ma, mb;
        int mode;
        mode = $urandom_range(0, 4);
        ea = 8'($urandom_range(0, 255));
        ma = {1'($urandom_range(0, 7) != 0), 23'($urandom), 3'($urandom_range(0, 7)), 1'b0};
        mb = {1'($urandom_range(0, 7) != 0), 23'($urandom), 3'($urandom_range(0, 7)), 1'b0};
        case (mode)
            0: eb = ea;
            1: eb = ea + 8'($urandom_range(0, 30));
            2: eb = ea - 8'($urandom_range(0, 30));
            3: eb = 8'($urandom_range(0, 255));
            default: begin eb = ea; mb = ma; end
        endcase
        a = mk(1'($urandom_range(0, 1)), ea, ma);
        b = mk(1'($urandom_range(0, 1)), eb, mb);
        o = 1'($urandom_range(0, 1));
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [36:0] a, input logic [36:0] b, input logic o,
                        input logic use_exp, input logic [38:0] given, output longint t_acc);
        logic acc;
        int   tries;
        bus.in_valid = 1'b1;
        bus.N_A = a;
        bus.N_B = b;
        bus.op  = o;
        acc   = 1'b0;
        t_acc = -1;
        tries = 0;
        while (!acc && tries < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            if (acc) t_acc = cyc;
            @(posedge clk);
            #1;
            tries++;
        end
        if (acc) begin
            exp_q.push_back(use_exp ? given : ref_model(a, b, o));
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready 0 for %0d cycles, required 1", tries);
        end
    endtask

    task automatic send_rand();
        logic [36:0] a, b;
        logic        o;
        longint      t;
        rand_pair(a, b, o);
        send(a, b, o, 1'b0, '0, t);
    endtask

    task automatic idle(input int k);
        bus.in_valid = 1'b0;
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int tries;
        tries = 0;
        while (exp_q.size() != 0 && tries < 1000) begin
            @(posedge clk);
            #1;
            tries++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_outputs"}, {bus.res_sign, bus.res_exp, bus.res_sum, bus.res_zero}, 39'd0);
        check({name, "_out_valid"}, {38'd0, bus.out_valid}, 39'd0);
        check({name, "_in_ready"}, {38'd0, bus.in_ready}, 39'd1);
    endtask

    // Monitor: compares on every output transfer and checks stability while stalled
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            cur = {bus.res_sign, bus.res_exp, bus.res_sum, bus.res_zero};
            if (held) begin
                check("hold_valid", {38'd0, bus.out_valid}, 39'd1);
                check("hold_stable", cur, held_val);
            end
            if (bus.out_valid && bus.out_ready) begin
                held = 1'b0;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h, required no result", cur);
                end else begin
                    check("result", cur, exp_q.pop_front());
                end
            end else if (bus.out_valid) begin
                held     = 1'b1;
                held_val = cur;
                check("in_ready_stall", {38'd0, bus.in_ready}, 39'd0);
            end else begin
                held = 1'b0;
            end
        end
    end

    logic [36:0] da[10];
    logic [36:0] db[10];
    logic        dop[10];
    logic [38:0] dexp[10];

    initial begin
        longint t_acc;
        longint lat;
        int     n;

        bus.in_valid  = 1'b0;
        bus.N_A       = '0;
        bus.N_B       = '0;
        bus.op        = 1'b0;
        bus.out_ready = 1'b1;

        #1 rst = 1'b1;
        #1 check_reset_state("reset_initial");
        @(posedge clk);
        #1 rst = 1'b0;

        da[0] = mk(0, 127, 28'h8000000); db[0] = mk(0, 127, 28'h8000000); dop[0] = 0;
        dexp[0] = {1'b0, 8'd127, 29'h10000000, 1'b0};
        da[1] = mk(0, 127, 28'h8000000); db[1] = mk(0, 127, 28'h8000000); dop[1] = 1;
        dexp[1] = {1'b0, 8'd127, 29'h0, 1'b1};
        da[2] = mk(1, 127, 28'h8000000); db[2] = mk(0, 127, 28'h8000000); dop[2] = 0;
        dexp[2] = {1'b0, 8'd127, 29'h0, 1'b1};
        da[3] = mk(1, 127, 28'h8000000); db[3] = mk(1, 127, 28'h8000000); dop[3] = 1;
        dexp[3] = {1'b0, 8'd127, 29'h0, 1'b1};
        da[4] = mk(1, 0, 28'h0); db[4] = mk(1, 0, 28'h0); dop[4] = 0;
        dexp[4] = {1'b1, 8'd0, 29'h0, 1'b1};
        da[5] = mk(0, 126, 28'h8000000); db[5] = mk(0, 127, 28'h8000000); dop[5] = 1;
        dexp[5] = {1'b1, 8'd127, 29'h4000000, 1'b0};
        da[6] = mk(0, 130, 28'h8000000); db[6] = mk(0, 100, 28'h8000000); dop[6] = 0;
        dexp[6] = {1'b0, 8'd130, 29'h8000002, 1'b0};
        da[7] = mk(0, 154, 28'h8000000); db[7] = mk(0, 127, 28'h8000000); dop[7] = 0;
        dexp[7] = {1'b0, 8'd154, 29'h8000002, 1'b0};
        da[8] = mk(0, 152, 28'h8000000); db[8] = mk(0, 127, 28'h8000010); dop[8] = 0;
        dexp[8] = {1'b0, 8'd152, 29'h8000006, 1'b0};
        da[9] = mk(0, 128, 28'h8000000); db[9] = mk(0, 127, 28'h800000A); dop[9] = 1;
        dexp[9] = {1'b0, 8'd128, 29'h3FFFFFA, 1'b0};

        // Directed corners, streamed back to back
        for (int i = 0; i < 10; i++) send(da[i], db[i], dop[i], 1'b1, dexp[i], t_acc);
        idle(1);
        wait_drain();

        // Backpressure: stall after the first result, then release
        fork
            begin
                for (int i = 0; i < 5; i++) send_rand();
                idle(0);
            end
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!bus.out_valid && n < 20);
                @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (6) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        wait_drain();
        idle(2);

        // Reset with three pairs in flight
        for (int i = 0; i < 3; i++) send_rand();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        #1 check_reset_state("reset_midstream");
        @(posedge clk);
        #1 rst = 1'b0;
        idle(1);

        // Latency of the first pair after reset
        send(mk(0, 127, 28'h8000000), mk(0, 126, 28'hC000000), 1'b0, 1'b0, '0, t_acc);
        bus.in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 10);
        lat = cyc - t_acc;
        check("latency", 39'(lat), 39'd3);
        wait_drain();

        // Random stream with random gaps and random backpressure
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                    send_rand();
                end
                idle(0);
                wait_drain();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
